swap_exchange_unit: RTL and testbench
=====================================

// Module: swap_exchange_unit
// PURPOSE
//  Register-file exchange engine: DEPTH words of WIDTH bits with WRITE, SWAP(a,b), ROT_L and ROT_R commands.
//  Accepts commands over a valid/ready handshake.
//  SERIAL selects how exchanges execute:
//   - SERIAL=0: single-cycle parallel update (non-blocking style).
//   - SERIAL=1: multi-cycle temp-register sequence (blocking-style temp/a/b).
//  Shared datapath primitive for test and shuffle logic.
// PARAMETERS
//  WIDTH  8  data word width, >=1
//  DEPTH  4  number of registers, >=2; AW = max(1, $clog2(DEPTH))
//  SERIAL 0  0: parallel exchange; 1: sequential exchange through temp register
// PORTS
//  clk        in   1      sole clock, all state on posedge
//  rst        in   1      synchronous active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      unit can accept; = (state==IDLE) && !rst
//  cmd_op     in   2      00 WRITE, 01 SWAP, 10 ROT_L, 11 ROT_R
//  cmd_idx_a  in   AW     WRITE target / SWAP first index
//  cmd_idx_b  in   AW     SWAP second index
//  cmd_data   in   WIDTH  WRITE data
//  rd_idx     in   AW     combinational read index
//  rd_data    out  WIDTH  reg[rd_idx]; 0 if rd_idx>=DEPTH
//  dbg_temp   out  WIDTH  current temp register
//  busy       out  1      !cmd_ready
//  done       out  1      1-cycle pulse: command completed
//  err        out  1      1-cycle pulse with done: index >= DEPTH, no state change
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - All regs, temp, done and err cleared to 0; state -> IDLE.
//   - Overrides any in-flight command: abort, no done. cmd_ready=1 in the first cycle after rst drops.
//  Accept: cmd_valid & cmd_ready at edge E0. Command fields are captured at E0; later changes are ignored.
//  Index check:
//   - Any used index >= DEPTH: no register or temp change; done=err=1 in cycle after E0 (both modes).
//  WRITE (both modes): reg[a] <= cmd_data at E0; done in cycle after E0.
//  SERIAL=0:
//   - SWAP: reg[a]<=reg[b] and reg[b]<=reg[a] at E0.
//   - ROT_L: reg[i]<=reg[(i+1)%DEPTH] at E0.
//   - ROT_R: reg[i]<=reg[(i-1)%DEPTH] at E0.
//   - done in cycle after E0; temp unused (holds 0).
//   - cmd_ready stays 1, so back-to-back commands are accepted every cycle.
//  SERIAL=1 SWAP: FSM IDLE->S_A->S_B->IDLE.
//   - E0: temp<=reg[a].
//   - E1: reg[a]<=reg[b].
//   - E2: reg[b]<=temp; done in cycle after E2.
//   - cmd_ready low for 2 cycles.
//  SERIAL=1 ROT_L: FSM IDLE->R_SH->R_FIN; counter k.
//   - E0: temp<=reg[0], k=0.
//   - Each R_SH edge: reg[k]<=reg[k+1], k++ until k=DEPTH-2.
//   - R_FIN edge: reg[DEPTH-1]<=temp.
//   - Total DEPTH+1 edges; done after the last edge.
//  SERIAL=1 ROT_R: mirror of ROT_L.
//   - E0: temp<=reg[DEPTH-1].
//   - R_SH edges: reg[k]<=reg[k-1] for k=DEPTH-1..1.
//   - Final edge: reg[0]<=temp.
//  SWAP with a==b: legal, values unchanged, same latency as any other SWAP, done pulses.
//  rd_data is live: intermediate serial states are visible. A same-cycle read returns the pre-edge value.
//  cmd_valid without ready is ignored, not queued.
// TESTING
//  1. Reset, WRITE r0=10, WRITE r1=20, SWAP(0,1) -> r0=20, r1=10; done one cycle after each accept.
//  2. SERIAL=1, same SWAP:
//     - dbg_temp=10 after E0; r0=20/r1=20 after E1; r1=10 after E2.
//     - cmd_ready low 2 cycles; done cycle after E2.
//  3. DEPTH=4, regs {1,2,3,4}: ROT_L -> {2,3,4,1}; ROT_R -> {1,2,3,4}. Both modes; SERIAL=1 takes 5 edges each.
//  4. DEPTH=3, SWAP(0,3) -> done=err=1, regs unchanged; rd_idx=3 -> rd_data=0.
//  5. SERIAL=1 SWAP, rst asserted at E1 -> all regs/temp 0, no done, cmd_ready=1 next cycle.
//  6. SERIAL=0, SWAP(0,1) on two consecutive cycles from {10,20} -> {10,20}, two done pulses; SWAP(2,2) -> no change, done=1.

Source files
------------

// File: rtl/swap_exchange_unit.sv
// Register-file exchange engine: WRITE / SWAP / ROT_L / ROT_R over a valid/ready handshake,
// executed as a single-cycle parallel update (SERIAL=0) or a temp-register sequence (SERIAL=1).
module swap_exchange_unit #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SERIAL = 0,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_idx_a,
  input  logic [AW-1:0]    cmd_idx_b,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] dbg_temp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_ROT_L = 2'b10;

  typedef enum logic [2:0] {IDLE, S_A, S_B, R_SH, R_FIN} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] temp;
  logic [1:0]       op_q;
  logic [AW-1:0]    a_q;
  logic [AW-1:0]    b_q;
  logic [AW-1:0]    k;
  logic [AW-1:0]    k_last_c;
  logic             accept_c;
  logic             bad_c;
  logic             done_n;
  logic             err_n;

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = !cmd_ready;
  assign accept_c  = cmd_valid && cmd_ready;
  assign dbg_temp  = temp;
  assign rd_data   = (int'(rd_idx) < DEPTH) ? regs[rd_idx] : '0;
  // Last shift position: ROT_L walks k upward to DEPTH-2, ROT_R walks down to 1.
  assign k_last_c  = (op_q == OP_ROT_L) ? AW'(DEPTH - 2) : AW'(1);

  // Only WRITE and SWAP carry indices that can fall outside the register file.
  always_comb begin
    bad_c = 1'b0;
    case (cmd_op)
      OP_WRITE: bad_c = int'(cmd_idx_a) >= DEPTH;
      OP_SWAP:  bad_c = (int'(cmd_idx_a) >= DEPTH) || (int'(cmd_idx_b) >= DEPTH);
      default:  bad_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (bad_c) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else if ((SERIAL == 0) || (cmd_op == OP_WRITE)) begin
            done_n = 1'b1;
          end else if (cmd_op == OP_SWAP) begin
            state_n = S_A;
          end else begin
            state_n = R_SH;
          end
        end
      end
      S_A:  state_n = S_B;
      S_B: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      R_SH: begin
        if (k == k_last_c) state_n = R_FIN;
      end
      R_FIN: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      temp <= '0;
      op_q <= OP_WRITE;
      a_q  <= '0;
      b_q  <= '0;
      k    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= done_n;
      err  <= err_n;
      case (state)
        IDLE: begin
          if (accept_c && !bad_c) begin
            op_q <= cmd_op;
            a_q  <= cmd_idx_a;
            b_q  <= cmd_idx_b;
            case (cmd_op)
              OP_WRITE: regs[cmd_idx_a] <= cmd_data;
              OP_SWAP: begin
                if (SERIAL == 0) begin
                  regs[cmd_idx_a] <= regs[cmd_idx_b];
                  regs[cmd_idx_b] <= regs[cmd_idx_a];
                end else begin
                  temp <= regs[cmd_idx_a];
                end
              end
              OP_ROT_L: begin
                if (SERIAL == 0) begin
                  for (int i = 0; i < DEPTH; i++)
                    regs[AW'(i)] <= regs[AW'((i + 1) % DEPTH)];
                end else begin
                  temp <= regs[AW'(0)];
                  k    <= '0;
                end
              end
              default: begin
                if (SERIAL == 0) begin
                  for (int i = 0; i < DEPTH; i++)
                    regs[AW'(i)] <= regs[AW'((i + DEPTH - 1) % DEPTH)];
                end else begin
                  temp <= regs[AW'(DEPTH - 1)];
                  k    <= AW'(DEPTH - 1);
                end
              end
            endcase
          end
        end
        S_A: regs[a_q] <= regs[b_q];
        S_B: regs[b_q] <= temp;
        R_SH: begin
          if (op_q == OP_ROT_L) begin
            regs[k] <= regs[k + AW'(1)];
            k       <= k + AW'(1);
          end else begin
            regs[k] <= regs[k - AW'(1)];
            k       <= k - AW'(1);
          end
        end
        R_FIN: begin
          if (op_q == OP_ROT_L) regs[AW'(DEPTH - 1)] <= temp;
          else                  regs[AW'(0)]         <= temp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_exchange_unit.sv
// Bench for swap_exchange_unit: three instances (parallel D4, serial D4, serial D3) checked
// against a queue-based register-file model with per-mode latency expectations.
module tb_swap_exchange_unit;

  localparam int W    = 8;
  localparam int AW   = 2;
  localparam int NDUT = 3;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_ROTL  = 2'b10;
  localparam logic [1:0] OP_ROTR  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_idx_a;
  logic [AW-1:0] cmd_idx_b;
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  cmd_data;
  logic          cmd_valid [NDUT];
  logic          cmd_ready [NDUT];
  logic          busy      [NDUT];
  logic          done      [NDUT];
  logic          err       [NDUT];
  logic [W-1:0]  rd_data   [NDUT];
  logic [W-1:0]  dbg_temp  [NDUT];

  int tests_run    = 0;
  int tests_failed = 0;
  int dep [NDUT] = '{4, 4, 3};
  bit ser [NDUT] = '{1'b0, 1'b1, 1'b1};
  logic [W-1:0] mdl      [NDUT][4];
  logic [W-1:0] mdl_temp [NDUT];

  always #10 clk = ~clk;

  swap_exchange_unit #(.WIDTH(W), .DEPTH(4), .SERIAL(0)) u_par (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
    .cmd_idx_a(cmd_idx_a), .cmd_idx_b(cmd_idx_b), .cmd_data(cmd_data), .rd_idx(rd_idx),
    .rd_data(rd_data[0]), .dbg_temp(dbg_temp[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

  swap_exchange_unit #(.WIDTH(W), .DEPTH(4), .SERIAL(1)) u_ser (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
    .cmd_idx_a(cmd_idx_a), .cmd_idx_b(cmd_idx_b), .cmd_data(cmd_data), .rd_idx(rd_idx),
    .rd_data(rd_data[1]), .dbg_temp(dbg_temp[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  swap_exchange_unit #(.WIDTH(W), .DEPTH(3), .SERIAL(1)) u_d3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]), .cmd_op(cmd_op),
    .cmd_idx_a(cmd_idx_a), .cmd_idx_b(cmd_idx_b), .cmd_data(cmd_data), .rd_idx(rd_idx),
    .rd_data(rd_data[2]), .dbg_temp(dbg_temp[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

  function automatic bit is_bad(input int s, input logic [1:0] op, input int a, input int b);
    if (op == OP_WRITE) return a >= dep[s];
    if (op == OP_SWAP)  return (a >= dep[s]) || (b >= dep[s]);
    return 1'b0;
  endfunction

  // Edges from accept to completion: one for parallel/WRITE/error, SWAP 3, rotate DEPTH+1.
  function automatic int exp_lat(input int s, input logic [1:0] op, input int a, input int b);
    if (is_bad(s, op, a, b) || !ser[s] || op == OP_WRITE) return 1;
    if (op == OP_SWAP) return 3;
    return dep[s] + 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NDUT; s++) begin
      mdl_temp[s] = '0;
      for (int i = 0; i < 4; i++) mdl[s][i] = '0;
    end
  endtask

  task automatic model_apply(input int s, input logic [1:0] op, input int a, input int b,
                             input logic [W-1:0] d);
    logic [W-1:0] q [$];
    logic [W-1:0] t;
    if (is_bad(s, op, a, b)) return;
    q = {};
    for (int i = 0; i < dep[s]; i++) q.push_back(mdl[s][i]);
    case (op)
      OP_WRITE: q[a] = d;
      OP_SWAP: begin
        t = q[a]; q[a] = q[b]; q[b] = t;
        if (ser[s]) mdl_temp[s] = t;
      end
      OP_ROTL: begin
        if (ser[s]) mdl_temp[s] = q[0];
        q.push_back(q.pop_front());
      end
      default: begin
        if (ser[s]) mdl_temp[s] = q[dep[s] - 1];
        q.push_front(q.pop_back());
      end
    endcase
    for (int i = 0; i < dep[s]; i++) mdl[s][i] = q[i];
  endtask

  task automatic rd(input int s, input int idx, output logic [W-1:0] v);
    rd_idx = AW'(idx);
    #1;
    v = rd_data[s];
  endtask

  // Issue one command, observe latency/error/handshake/pulse width, then update the model.
  task automatic exec(input int s, input logic [1:0] op, input int a, input int b,
                      input logic [W-1:0] d, output int edges, output bit saw_err,
                      output bit ready_ok, output bit pulse_ok);
    @(negedge clk);
    ready_ok = (cmd_ready[s] === 1'b1);
    cmd_op = op; cmd_idx_a = AW'(a); cmd_idx_b = AW'(b); cmd_data = d;
    cmd_valid[s] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[s] = 1'b0;
    cmd_op = 2'($urandom); cmd_idx_a = AW'($urandom); cmd_idx_b = AW'($urandom);
    cmd_data = W'($urandom);
    edges = 1;
    while (done[s] !== 1'b1 && edges < 40) begin
      if (cmd_ready[s] !== 1'b0 || busy[s] !== 1'b1) ready_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    if (done[s] !== 1'b1) edges = -1;
    saw_err = (err[s] === 1'b1);
    if (cmd_ready[s] !== 1'b1) ready_ok = 1'b0;
    @(posedge clk); #1;
    pulse_ok = (done[s] === 1'b0) && (err[s] === 1'b0);
    model_apply(s, op, a, b, d);
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    for (int s = 0; s < NDUT; s++) begin
      tests_run++;
      if (cmd_ready[s] !== 1'b1 || busy[s] !== 1'b0 || done[s] !== 1'b0 || err[s] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ctrl dut%0d: ready=%b busy=%b done=%b err=%b, expected 1 0 0 0",
                 s, cmd_ready[s], busy[s], done[s], err[s]);
      end
      tests_run++;
      if (dbg_temp[s] !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_temp dut%0d: got %0d expected 0", s, dbg_temp[s]);
      end
      for (int i = 0; i < dep[s]; i++) begin
        rd(s, i, v);
        tests_run++;
        if (v !== 8'd0) begin
          tests_failed++;
          $display("FAIL reset_reg dut%0d r%0d: got %0d expected 0", s, i, v);
        end
      end
    end
  endtask

  task automatic test_write_swap();
    int e; bit se, ro, po; logic [W-1:0] v0, v1;
    for (int s = 0; s < 2; s++) begin
      exec(s, OP_WRITE, 0, 0, 8'd10, e, se, ro, po);
      tests_run++;
      if (e !== 1 || se !== 1'b0 || !po) begin
        tests_failed++;
        $display("FAIL write_lat dut%0d: edges=%0d err=%b pulse=%b expected 1 0 1", s, e, se, po);
      end
      exec(s, OP_WRITE, 1, 0, 8'd20, e, se, ro, po);
      exec(s, OP_SWAP, 0, 1, 8'd0, e, se, ro, po);
      tests_run++;
      if (e !== exp_lat(s, OP_SWAP, 0, 1) || se !== 1'b0 || !ro || !po) begin
        tests_failed++;
        $display("FAIL swap_lat dut%0d: edges=%0d err=%b ready_ok=%b pulse=%b expected %0d 0 1 1",
                 s, e, se, ro, po, exp_lat(s, OP_SWAP, 0, 1));
      end
      rd(s, 0, v0);
      rd(s, 1, v1);
      tests_run++;
      if (v0 !== 8'd20 || v1 !== 8'd10) begin
        tests_failed++;
        $display("FAIL swap_vals dut%0d: r0=%0d r1=%0d expected 20 10", s, v0, v1);
      end
    end
  endtask

  task automatic test_serial_trace();
    int e; bit se, ro, po; logic [W-1:0] v0, v1;
    exec(1, OP_WRITE, 0, 0, 8'd10, e, se, ro, po);
    exec(1, OP_WRITE, 1, 0, 8'd20, e, se, ro, po);
    @(negedge clk);
    cmd_op = OP_SWAP; cmd_idx_a = 2'd0; cmd_idx_b = 2'd1; cmd_valid[1] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0; cmd_idx_a = 2'd3; cmd_idx_b = 2'd2;
    rd(1, 0, v0);
    tests_run++;
    if (dbg_temp[1] !== 8'd10 || cmd_ready[1] !== 1'b0 || done[1] !== 1'b0 || v0 !== 8'd10) begin
      tests_failed++;
      $display("FAIL trace_e0: temp=%0d ready=%b done=%b r0=%0d expected 10 0 0 10",
               dbg_temp[1], cmd_ready[1], done[1], v0);
    end
    @(posedge clk); #1;
    rd(1, 0, v0);
    rd(1, 1, v1);
    tests_run++;
    if (v0 !== 8'd20 || v1 !== 8'd20 || cmd_ready[1] !== 1'b0 || done[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL trace_e1: r0=%0d r1=%0d ready=%b done=%b expected 20 20 0 0",
               v0, v1, cmd_ready[1], done[1]);
    end
    @(posedge clk); #1;
    rd(1, 0, v0);
    rd(1, 1, v1);
    tests_run++;
    if (v0 !== 8'd20 || v1 !== 8'd10 || cmd_ready[1] !== 1'b1 || done[1] !== 1'b1 || err[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL trace_e2: r0=%0d r1=%0d ready=%b done=%b err=%b expected 20 10 1 1 0",
               v0, v1, cmd_ready[1], done[1], err[1]);
    end
    model_apply(1, OP_SWAP, 0, 1, 8'd0);
  endtask

  task automatic test_rotate();
    int e; bit se, ro, po; logic [W-1:0] v;
    for (int s = 0; s < NDUT; s++) begin
      for (int i = 0; i < dep[s]; i++) exec(s, OP_WRITE, i, 0, W'(i + 1), e, se, ro, po);
      for (int r = 0; r < 2; r++) begin
        exec(s, (r == 0) ? OP_ROTL : OP_ROTR, 0, 0, 8'd0, e, se, ro, po);
        tests_run++;
        if (e !== (ser[s] ? dep[s] + 1 : 1) || se !== 1'b0 || !ro || !po) begin
          tests_failed++;
          $display("FAIL rot_lat dut%0d dir%0d: edges=%0d err=%b ready_ok=%b pulse=%b expected %0d 0 1 1",
                   s, r, e, se, ro, po, ser[s] ? dep[s] + 1 : 1);
        end
        for (int i = 0; i < dep[s]; i++) begin
          rd(s, i, v);
          tests_run++;
          if (v !== mdl[s][i]) begin
            tests_failed++;
            $display("FAIL rot_reg dut%0d dir%0d r%0d: got %0d expected %0d", s, r, i, v, mdl[s][i]);
          end
        end
      end
    end
  endtask

  task automatic test_index_error();
    int e; bit se, ro, po; logic [W-1:0] v;
    for (int i = 0; i < 3; i++) exec(2, OP_WRITE, i, 0, W'(i + 5), e, se, ro, po);
    exec(2, OP_SWAP, 0, 1, 8'd0, e, se, ro, po);
    exec(2, OP_SWAP, 0, 3, 8'd0, e, se, ro, po);
    tests_run++;
    if (e !== 1 || se !== 1'b1 || !ro || !po) begin
      tests_failed++;
      $display("FAIL swap_oob: edges=%0d err=%b ready_ok=%b pulse=%b expected 1 1 1 1", e, se, ro, po);
    end
    exec(2, OP_WRITE, 3, 0, 8'hee, e, se, ro, po);
    tests_run++;
    if (e !== 1 || se !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_oob: edges=%0d err=%b expected 1 1", e, se);
    end
    exec(2, OP_SWAP, 1, 1, 8'd0, e, se, ro, po);
    tests_run++;
    if (e !== 3 || se !== 1'b0 || !po) begin
      tests_failed++;
      $display("FAIL swap_same_serial: edges=%0d err=%b pulse=%b expected 3 0 1", e, se, po);
    end
    tests_run++;
    if (dbg_temp[2] !== mdl_temp[2]) begin
      tests_failed++;
      $display("FAIL oob_temp: got %0d expected %0d", dbg_temp[2], mdl_temp[2]);
    end
    for (int i = 0; i < 4; i++) begin
      rd(2, i, v);
      tests_run++;
      if (v !== ((i < 3) ? mdl[2][i] : 8'd0)) begin
        tests_failed++;
        $display("FAIL oob_reg r%0d: got %0d expected %0d", i, v, (i < 3) ? mdl[2][i] : 8'd0);
      end
    end
  endtask

  task automatic test_reset_abort();
    int e; bit se, ro, po; logic [W-1:0] v;
    exec(1, OP_WRITE, 0, 0, 8'd33, e, se, ro, po);
    exec(1, OP_WRITE, 1, 0, 8'd44, e, se, ro, po);
    @(negedge clk);
    cmd_op = OP_SWAP; cmd_idx_a = 2'd0; cmd_idx_b = 2'd1; cmd_valid[1] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (done[1] !== 1'b0 || cmd_ready[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_in_rst: done=%b ready=%b expected 0 0", done[1], cmd_ready[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (cmd_ready[1] !== 1'b1 || dbg_temp[1] !== 8'd0 || done[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_after: ready=%b temp=%0d done=%b expected 1 0 0",
               cmd_ready[1], dbg_temp[1], done[1]);
    end
    for (int i = 0; i < 4; i++) begin
      rd(1, i, v);
      tests_run++;
      if (v !== 8'd0) begin
        tests_failed++;
        $display("FAIL abort_reg r%0d: got %0d expected 0", i, v);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      tests_run++;
      if (done[1] !== 1'b0 || cmd_ready[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL abort_no_done: done=%b ready=%b expected 0 1", done[1], cmd_ready[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e; bit se, ro, po; logic [W-1:0] v0, v1;
    exec(0, OP_WRITE, 0, 0, 8'd10, e, se, ro, po);
    exec(0, OP_WRITE, 1, 0, 8'd20, e, se, ro, po);
    @(negedge clk);
    cmd_op = OP_SWAP; cmd_idx_a = 2'd0; cmd_idx_b = 2'd1; cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    rd(0, 0, v0);
    tests_run++;
    if (done[0] !== 1'b1 || cmd_ready[0] !== 1'b1 || v0 !== 8'd20) begin
      tests_failed++;
      $display("FAIL b2b_first: done=%b ready=%b r0=%0d expected 1 1 20", done[0], cmd_ready[0], v0);
    end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    rd(0, 0, v0);
    rd(0, 1, v1);
    tests_run++;
    if (done[0] !== 1'b1 || v0 !== 8'd10 || v1 !== 8'd20) begin
      tests_failed++;
      $display("FAIL b2b_second: done=%b r0=%0d r1=%0d expected 1 10 20", done[0], v0, v1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: done=%b expected 0", done[0]);
    end
    exec(0, OP_WRITE, 2, 0, 8'd77, e, se, ro, po);
    exec(0, OP_SWAP, 2, 2, 8'd0, e, se, ro, po);
    rd(0, 2, v0);
    tests_run++;
    if (e !== 1 || se !== 1'b0 || v0 !== 8'd77) begin
      tests_failed++;
      $display("FAIL swap_same_par: edges=%0d err=%b r2=%0d expected 1 0 77", e, se, v0);
    end
  endtask

  task automatic test_random();
    int e; bit se, ro, po; logic [W-1:0] v;
    logic [1:0] op; int a, b;
    for (int s = 0; s < NDUT; s++) begin
      for (int n = 0; n < 40; n++) begin
        op = 2'($urandom);
        if (n % 3 == 0) op = OP_WRITE;
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        exec(s, op, a, b, W'($urandom), e, se, ro, po);
        tests_run++;
        if (e !== exp_lat(s, op, a, b) || se !== is_bad(s, op, a, b) || !ro || !po) begin
          tests_failed++;
          $display("FAIL rand_ctrl dut%0d op%0d a%0d b%0d: edges=%0d err=%b ready_ok=%b pulse=%b expected %0d %b 1 1",
                   s, op, a, b, e, se, ro, po, exp_lat(s, op, a, b), is_bad(s, op, a, b));
        end
        tests_run++;
        if (dbg_temp[s] !== mdl_temp[s]) begin
          tests_failed++;
          $display("FAIL rand_temp dut%0d: got %0d expected %0d", s, dbg_temp[s], mdl_temp[s]);
        end
        for (int i = 0; i < dep[s]; i++) begin
          rd(s, i, v);
          tests_run++;
          if (v !== mdl[s][i]) begin
            tests_failed++;
            $display("FAIL rand_reg dut%0d r%0d: got %0d expected %0d", s, i, v, mdl[s][i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_op = OP_WRITE; cmd_idx_a = '0; cmd_idx_b = '0; cmd_data = '0; rd_idx = '0;
    for (int s = 0; s < NDUT; s++) cmd_valid[s] = 1'b0;
    test_reset();
    test_write_swap();
    test_serial_trace();
    test_rotate();
    test_index_error();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
